// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// default bit period used by both the receiver and the transmitter.
package uart_pkg;

  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Circular byte FIFO with pointers one bit wider than the address so that
// full and empty are distinguished without a separate count.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 LSB first with back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_fifo_full,
  output logic       o_overflow
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  tx_state_t                 state_d;
  logic [CW-1:0]             clk_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_empty;
  logic                      pop;
  logic                      bit_end;
  logic                      serial_d;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (i_tx_dv),
    .wr_data (i_tx_byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (o_fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (clk_cnt == LAST_CNT);

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    serial_d = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        serial_d = shift[bit_idx];
        if (bit_end && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = ^shift;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_tx_serial <= UART_IDLE_LEVEL;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state <= state_d;
      if ((state == IDLE) || bit_end) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 1'b1;
      if (state != DATA) bit_idx <= '0;
      else if (bit_end)  bit_idx <= bit_idx + 1'b1;
      if (pop) shift <= fifo_data;
      // Line outputs are registered copies of the current state's decode.
      o_tx_serial <= serial_d;
      o_tx_active <= (state != IDLE);
      o_tx_done   <= (state == STOP) && bit_end;
      if (i_tx_dv && o_fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: transaction-level FIFO/timing model feeding an
// expected-byte queue, and a UART line decoder that checks each frame.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       serial, active, done, full, ovf;

  uart_tx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tx_dv     (dv),
    .i_tx_byte   (byte_in),
    .o_tx_serial (serial),
    .o_tx_active (active),
    .o_tx_done   (done),
    .o_fifo_full (full),
    .o_overflow  (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no++;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mq[$];       // bytes the model holds in the FIFO
  logic [7:0] exp_q[$];    // bytes expected on the line, in order
  int         next_pop = 0;
  logic       model_ovf = 1'b0;
  int         acc_cnt = 0;
  int         rx_cnt = 0;
  int         done_cnt = 0;
  int         rst_gen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; models the coming posedge: a stored byte leaves the
  // FIFO as soon as the transmitter is free, and each frame occupies FRAME
  // cycles from its pop to the pop of the following byte.
  task automatic cycle(input logic d, input logic [7:0] b);
    int   sz;
    logic p;
    dv      = d;
    byte_in = b;
    sz = mq.size();
    p  = (sz > 0) && (edge_no >= next_pop);
    if (p) begin
      void'(mq.pop_front());
      next_pop = edge_no + FRAME;
    end
    if (d) begin
      if ((sz < DEPTH) || p) begin
        mq.push_back(b);
        exp_q.push_back(b);
        acc_cnt++;
      end else begin
        model_ovf = 1'b1;
      end
    end
    @(negedge clk);
    dv = 1'b0;
    check("fifo_full", full, (mq.size() == DEPTH));
    check("overflow", ovf, model_ovf);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    rst_gen++;
    #1;
    check("rst_serial", serial, UART_IDLE_LEVEL);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    check("rst_overflow", ovf, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    exp_q.delete();
    next_pop  = 0;
    model_ovf = 1'b0;
    acc_cnt   = 0;
    rx_cnt    = 0;
    done_cnt  = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((mq.size() > 0) || (edge_no < next_pop + 4)) && (n < 5000)) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    check("drain_timeout", (n < 5000), 1);
    check("rx_count", rx_cnt, acc_cnt);
    check("done_count", done_cnt, acc_cnt);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  // Single byte from idle, checked cycle by cycle against the frame layout.
  task automatic send_exact(input logic [7:0] b);
    logic [NB-1:0] bits;
    logic          es;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
`ifdef UART_TX_PARITY_EN
    bits[9]    = ^b;
`endif
    bits[NB-1] = 1'b1;
    cycle(1'b1, b);
    check("exact_idle", serial, 1);
    for (int k = 1; k <= FRAME + 3; k++) begin
      cycle(1'b0, 8'h00);
      es = ((k >= 2) && (k < FRAME + 2)) ? bits[(k - 2) / C] : 1'b1;
      check("exact_serial", serial, es);
      check("exact_active", active, ((k >= 2) && (k < FRAME + 2)));
      check("exact_done", done, (k == FRAME + 1));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) if (rst_n && (done === 1'b1)) done_cnt++;

  initial begin : monitor
    int            g;
    logic [NB-1:0] rb;
    logic [7:0]    data;
    forever begin
      @(negedge clk);
      if (rst_n && (serial === 1'b0)) begin
        g = rst_gen;
        for (int j = 0; j < NB; j++) begin
          if (j == 0) repeat (C / 2) @(negedge clk);
          else        repeat (C) @(negedge clk);
          rb[j] = serial;
        end
        if (g == rst_gen) begin
          rx_cnt++;
          data = rb[8:1];
          check("start_bit", rb[0], 0);
          check("stop_bit", rb[NB-1], 1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", rb[9], ^data);
`endif
          check("frame_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("frame_data", data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int r0;
    int n;
    reset_dut();
    repeat (8) cycle(1'b0, 8'h00);

    // Single byte with exact timing.
    send_exact(8'hA5);
`ifdef UART_TX_PARITY_EN
    send_exact(8'h07);
    send_exact(8'h03);
`endif
    drain();

    // Burst of three: back-to-back frames, no overflow.
    cycle(1'b1, 8'h31);
    cycle(1'b1, 8'h32);
    cycle(1'b1, 8'h33);
    drain();
    check("burst_overflow", ovf, 0);

    // Fill to full, then write exactly on the edge the stop bit pops.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'h40 + i));
    check("fill_full", full, 1);
    n = 0;
    while ((edge_no != next_pop) && (n < 200)) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    check("pop_edge_timeout", (n < 200), 1);
    cycle(1'b1, 8'h5A);
    check("pop_write_full", full, 1);
    check("pop_write_ovf", ovf, 0);
    drain();

    // Six writes from idle: one pops, four fill, one dropped.
    r0 = rx_cnt;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom_range(0, 255)));
    check("six_full", full, 1);
    check("six_overflow", ovf, 1);
    drain();
    check("six_frames", rx_cnt - r0, 5);

    // Random traffic.
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 2) cycle(1'b1, 8'($urandom_range(0, 255)));
      else                          cycle(1'b0, 8'h00);
    end
    drain();

    // Reset during data bit 3 aborts the frame.
    cycle(1'b1, 8'hC3);
    for (int k = 1; k <= 2 + C * 4; k++) cycle(1'b0, 8'h00);
    check("pre_abort_active", active, 1);
    reset_dut();
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, 8'h00);
      check("post_reset_serial", serial, 1);
      check("post_reset_active", active, 0);
    end
    check("post_reset_frames", rx_cnt, 0);
    check("post_reset_done", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
